// File: rtl/cfg_rom_pkg.sv
// rtl/cfg_rom_pkg.sv - configuration record, table layout and response type for the config ROM
package cfg_rom_pkg;

  // Elaborated core configuration; each field is sized to the slot it occupies in the table.
  typedef struct packed {
    logic [15:0] XLEN;
    logic [15:0] VLEN;
    logic [3:0]  NrCommitPorts;
    logic [7:0]  NrScoreboardEntries;
    logic [7:0]  NrLoadBufEntries;
    logic        RVA;
    logic        RVB;
    logic        RVC;
    logic        RVD;
    logic        RVF;
    logic        RVH;
    logic        RVS;
    logic        RVU;
    logic        RVV;
    logic [31:0] IcacheByteSize;
    logic [7:0]  IcacheSetAssoc;
    logic [15:0] IcacheLineWidth;
    logic [31:0] DcacheByteSize;
    logic [7:0]  DcacheSetAssoc;
    logic [15:0] DcacheLineWidth;
    logic [7:0]  DCacheType;
    logic [15:0] BTBEntries;
    logic [15:0] BHTEntries;
    logic [7:0]  RASDepth;
    logic [7:0]  NrPMPEntries;
    logic [63:0] HaltAddress;
    logic [63:0] ExceptionAddress;
    logic [31:0] PLEN;
    logic [31:0] MemTidWidth;
  } cva6_cfg_t;

  localparam cva6_cfg_t CVA6_CFG_DEFAULT = '{
    XLEN: 16'd64, VLEN: 16'd64, NrCommitPorts: 4'd2, NrScoreboardEntries: 8'd8,
    NrLoadBufEntries: 8'd2,
    RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0,
    RVS: 1'b1, RVU: 1'b1, RVV: 1'b1,
    IcacheByteSize: 32'd16384, IcacheSetAssoc: 8'd4, IcacheLineWidth: 16'd128,
    DcacheByteSize: 32'd32768, DcacheSetAssoc: 8'd8, DcacheLineWidth: 16'd128,
    DCacheType: 8'd1,
    BTBEntries: 16'd32, BHTEntries: 16'd128, RASDepth: 8'd2, NrPMPEntries: 8'd8,
    HaltAddress: 64'h800, ExceptionAddress: 64'h808,
    PLEN: 32'd56, MemTidWidth: 32'd4
  };

  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned TID_MAX_W  = 16;
  localparam logic [63:0] CFG_MAGIC  = 64'h4356_4136_4346_4731;

  localparam logic [WORD_IDX_W-1:0] WORD_MAGIC  = 3'd0;
  localparam logic [WORD_IDX_W-1:0] WORD_CORE   = 3'd1;
  localparam logic [WORD_IDX_W-1:0] WORD_ISA    = 3'd2;
  localparam logic [WORD_IDX_W-1:0] WORD_ICACHE = 3'd3;
  localparam logic [WORD_IDX_W-1:0] WORD_DCACHE = 3'd4;
  localparam logic [WORD_IDX_W-1:0] WORD_BPRED  = 3'd5;
  localparam logic [WORD_IDX_W-1:0] WORD_HALT   = 3'd6;
  localparam logic [WORD_IDX_W-1:0] WORD_EXC    = 3'd7;

  localparam int unsigned CORE_XLEN_LSB  = 0;
  localparam int unsigned CORE_VLEN_LSB  = 16;
  localparam int unsigned CORE_NRCP_LSB  = 32;
  localparam int unsigned CORE_NRSB_LSB  = 36;
  localparam int unsigned CORE_NRLB_LSB  = 44;
  localparam int unsigned CACHE_SIZE_LSB = 0;
  localparam int unsigned CACHE_WAYS_LSB = 32;
  localparam int unsigned CACHE_LINE_LSB = 40;
  localparam int unsigned CACHE_TYPE_LSB = 56;
  localparam int unsigned BP_BTB_LSB     = 0;
  localparam int unsigned BP_BHT_LSB     = 16;
  localparam int unsigned BP_RAS_LSB     = 32;
  localparam int unsigned BP_PMP_LSB     = 40;

  typedef struct packed {
    logic [63:0]          data;
    logic [TID_MAX_W-1:0] tid;
    logic                 err;
  } cfg_rom_resp_t;

  // Builds one 64-bit table word; every bit not explicitly placed reads as zero.
  function automatic logic [63:0] cfg_word(input cva6_cfg_t cfg, input logic [WORD_IDX_W-1:0] idx);
    logic [63:0] w;
    logic        unused_bus_widths;
    w = '0;
    unused_bus_widths = ^{cfg.PLEN, cfg.MemTidWidth};
    case (idx)
      WORD_MAGIC: w = CFG_MAGIC;
      WORD_CORE: begin
        w[CORE_XLEN_LSB +: 16] = cfg.XLEN;
        w[CORE_VLEN_LSB +: 16] = cfg.VLEN;
        w[CORE_NRCP_LSB +: 4]  = cfg.NrCommitPorts;
        w[CORE_NRSB_LSB +: 8]  = cfg.NrScoreboardEntries;
        w[CORE_NRLB_LSB +: 8]  = cfg.NrLoadBufEntries;
      end
      WORD_ISA: begin
        w[0]  = cfg.RVA;
        w[1]  = cfg.RVB;
        w[2]  = cfg.RVC;
        w[3]  = cfg.RVD;
        w[5]  = cfg.RVF;
        w[7]  = cfg.RVH;
        w[18] = cfg.RVS;
        w[20] = cfg.RVU;
        w[21] = cfg.RVV;
      end
      WORD_ICACHE: begin
        w[CACHE_SIZE_LSB +: 32] = cfg.IcacheByteSize;
        w[CACHE_WAYS_LSB +: 8]  = cfg.IcacheSetAssoc;
        w[CACHE_LINE_LSB +: 16] = cfg.IcacheLineWidth;
      end
      WORD_DCACHE: begin
        w[CACHE_SIZE_LSB +: 32] = cfg.DcacheByteSize;
        w[CACHE_WAYS_LSB +: 8]  = cfg.DcacheSetAssoc;
        w[CACHE_LINE_LSB +: 16] = cfg.DcacheLineWidth;
        w[CACHE_TYPE_LSB +: 8]  = cfg.DCacheType;
      end
      WORD_BPRED: begin
        w[BP_BTB_LSB +: 16] = cfg.BTBEntries;
        w[BP_BHT_LSB +: 16] = cfg.BHTEntries;
        w[BP_RAS_LSB +: 8]  = cfg.RASDepth;
        w[BP_PMP_LSB +: 8]  = cfg.NrPMPEntries;
      end
      WORD_HALT: w = cfg.HaltAddress;
      WORD_EXC:  w = cfg.ExceptionAddress;
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cva6_cfg_rom_responder_resp_fifo.sv
// rtl/cva6_cfg_rom_responder_resp_fifo.sv - generic depth-N register FIFO with full/empty/count
module cfg_rom_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CNT_W = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap explicitly so any depth works.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = (wptr_q == PTR_W'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    if (do_pop)  rptr_d = (rptr_q == PTR_W'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cva6_cfg_rom_responder.sv
// rtl/cva6_cfg_rom_responder.sv - read-only responder serving the core configuration table
module cva6_cfg_rom_responder
  import cfg_rom_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg   = CVA6_CFG_DEFAULT,
  parameter logic [63:0] CfgBase   = 64'h0000_0000_0000_1000,
  parameter int unsigned RespDepth = 4,
  parameter int unsigned AddrWidth = CVA6Cfg.PLEN,
  parameter int unsigned TidWidth  = CVA6Cfg.MemTidWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [TidWidth-1:0]  tid_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [63:0]          rdata_o,
  output logic [TidWidth-1:0]  rtid_o,
  output logic                 rerr_o,
  output logic [15:0]          err_cnt_o
);

  localparam logic [AddrWidth-1:0] BASE   = CfgBase[AddrWidth-1:0];
  localparam int unsigned          RESP_W = $bits(cfg_rom_resp_t);
  localparam int unsigned          CNT_W  = $clog2(RespDepth + 1);

  logic [AddrWidth-1:0] off;
  logic                 below, misal, oor, acc_err, accept;
  cfg_rom_resp_t        resp, head;
  logic [RESP_W-1:0]    head_bits;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty, unused_fifo_full;
  logic [TID_MAX_W-1:0] unused_head_tid;
  logic [15:0]          err_cnt_q, err_cnt_d;

  // Address decode and response formation; the whole table is an elaboration-time constant.
  always_comb begin
    off       = addr_i - BASE;
    below     = (addr_i < BASE);
    misal     = (off[2:0] != 3'b000);
    oor       = (off[AddrWidth-1:3] >= (AddrWidth-3)'(NUM_WORDS));
    acc_err   = below || misal || oor || we_i;
    resp.err  = acc_err;
    resp.tid  = TID_MAX_W'(tid_i);
    resp.data = acc_err ? 64'h0 : cfg_word(CVA6Cfg, off[3 +: WORD_IDX_W]);
  end

  // A slot freed by a pop only becomes grantable once that pop has registered.
  assign gnt_o  = !rst_i && (fifo_count < CNT_W'(RespDepth));
  assign accept = req_i && gnt_o;

  cfg_rom_resp_fifo #(
    .Width (RESP_W),
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (resp),
    .pop_i   (rready_i),
    .data_o  (head_bits),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head            = cfg_rom_resp_t'(head_bits);
  assign unused_head_tid = head.tid;
  assign rvalid_o        = !fifo_empty;
  assign rdata_o         = head.data;
  assign rtid_o          = head.tid[TidWidth-1:0];
  assign rerr_o          = head.err;
  assign err_cnt_o       = err_cnt_q;

  // Error counter next-state: one per accepted errored request, saturating.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && acc_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

endmodule

// File: tb/tb_cva6_cfg_rom_responder.sv
// tb/tb_cva6_cfg_rom_responder.sv - scoreboard bench for cva6_cfg_rom_responder
module tb_cva6_cfg_rom_responder;

  localparam int AW = 56;
  localparam int TW = 4;
  localparam logic [AW-1:0] BASE_A = 56'h1000;

  logic          clk = 1'b0;
  logic          rst, req, we, rready;
  logic [AW-1:0] addr;
  logic [TW-1:0] tid;
  logic          gnt, rvalid, rerr;
  logic [63:0]   rdata;
  logic [TW-1:0] rtid;
  logic [15:0]   err_cnt;

  typedef struct packed {
    logic [63:0]   data;
    logic [TW-1:0] tid;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_err_cnt = 16'd0;
  logic [63:0] words [8];

  always #5 clk = ~clk;

  cva6_cfg_rom_responder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .tid_i     (tid),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .rdata_o   (rdata),
    .rtid_o    (rtid),
    .rerr_o    (rerr),
    .err_cnt_o (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic w);
    exp_t          e;
    logic [AW-1:0] o;
    e.tid = t;
    o     = a - BASE_A;
    if (w || (a < BASE_A) || (a[2:0] != 3'd0) || (a >= BASE_A + 56'd64)) begin
      e.data = 64'h0;
      e.err  = 1'b1;
    end else begin
      e.data = words[int'(o >> 3)];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // One clock: sample handshakes just before the edge, then score them after it.
  task automatic tick(output logic pushed);
    logic pop_fire, push_fire;
    exp_t got, e, pe;
    #1;
    pop_fire  = rvalid && rready;
    push_fire = req && gnt;
    got       = {rdata, rtid, rerr};
    pe        = model(addr, tid, we);
    @(posedge clk);
    #1;
    if (pop_fire) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", got.data, e.data);
        check("rtid", 64'(got.tid), 64'(e.tid));
        check("rerr", 64'(got.err), 64'(e.err));
      end
    end
    if (push_fire) begin
      sb.push_back(pe);
      if (pe.err && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
    end
    pushed = push_fire;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic w);
    logic p;
    int   n;
    req = 1'b1; addr = a; tid = t; we = w;
    p = 1'b0; n = 0;
    while (!p && n < 20) begin
      tick(p);
      n++;
    end
    if (!p) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic p;
    int   n;
    req = 1'b0; we = 1'b0; rready = 1'b1; n = 0;
    while ((sb.size() != 0 || rvalid) && n < 20) begin
      tick(p);
      n++;
    end
    check("drain_done", 64'(sb.size() == 0 && !rvalid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic p;
    int   n;
    words[0] = 64'h4356_4136_4346_4731;
    words[1] = 64'h0000_2082_0040_0040;
    words[2] = 64'h0000_0000_0034_002D;
    words[3] = 64'h0000_8004_0000_4000;
    words[4] = 64'h0100_8008_0000_8000;
    words[5] = 64'h0000_0802_0080_0020;
    words[6] = 64'h0000_0000_0000_0800;
    words[7] = 64'h0000_0000_0000_0808;

    rst = 1'b1; req = 1'b0; we = 1'b0; rready = 1'b0; addr = '0; tid = '0;
    repeat (2) tick(p);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rtid", 64'(rtid), 64'd0);
    check("rst_rerr", 64'(rerr), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    tick(p);
    check("gnt_after_release", 64'(gnt), 64'd1);

    // Single read, one-cycle latency.
    rready = 1'b1;
    req = 1'b1; addr = BASE_A + 56'h10; tid = 4'd2;
    tick(p);
    req = 1'b0;
    check("t1_accept", 64'(p), 64'd1);
    check("t1_rvalid", 64'(rvalid), 64'd1);
    check("t1_rdata", rdata, 64'h0000_0000_0034_002D);
    check("t1_rtid", 64'(rtid), 64'd2);
    check("t1_rerr", 64'(rerr), 64'd0);
    drain();

    // Back-to-back reads.
    send(BASE_A + 56'h00, 4'd0, 1'b0);
    send(BASE_A + 56'h18, 4'd1, 1'b0);
    send(BASE_A + 56'h30, 4'd3, 1'b0);
    drain();
    check("b2b_err_cnt", 64'(err_cnt), 64'd0);

    // Fill with no consumer, then watch grant recover.
    rready = 1'b0;
    send(BASE_A + 56'h08, 4'd5, 1'b0);
    send(BASE_A + 56'h10, 4'd6, 1'b0);
    send(BASE_A + 56'h20, 4'd7, 1'b0);
    send(BASE_A + 56'h28, 4'd8, 1'b0);
    check("full_gnt", 64'(gnt), 64'd0);
    req = 1'b1; addr = BASE_A + 56'h38; tid = 4'd9; we = 1'b0;
    tick(p);
    check("full_hold", 64'(p), 64'd0);
    rready = 1'b1;
    #1;
    check("no_bypass_gnt", 64'(gnt), 64'd0);
    tick(p);
    check("pop_cycle_accept", 64'(p), 64'd0);
    check("gnt_return", 64'(gnt), 64'd1);
    tick(p);
    check("fifth_accept", 64'(p), 64'd1);
    drain();

    // Error responses.
    send(BASE_A + 56'h0C, 4'd1, 1'b0);
    send(BASE_A + 56'h40, 4'd2, 1'b0);
    send(BASE_A - 56'h8,  4'd3, 1'b0);
    send(BASE_A,          4'd4, 1'b1);
    drain();
    check("err_cnt_four", 64'(err_cnt), 64'd4);
    check("err_cnt_model", 64'(err_cnt), 64'(exp_err_cnt));

    // Steady push+pop at occupancy 2, long enough to wrap both pointers.
    rready = 1'b0;
    send(BASE_A + 56'h00, 4'd10, 1'b0);
    send(BASE_A + 56'h08, 4'd11, 1'b0);
    rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; we = 1'b0; addr = BASE_A + 56'((i % 8) * 8); tid = 4'(i);
      tick(p);
      check("pp_accept", 64'(p), 64'd1);
    end
    rready = 1'b0;
    req = 1'b1; addr = BASE_A + 56'h30; tid = 4'd12;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick(p);
      if (p) n++;
    end
    check("pp_free_slots", 64'(n), 64'd2);
    drain();

    // Reset with three responses queued.
    rready = 1'b0;
    send(BASE_A + 56'h00, 4'd1, 1'b0);
    send(BASE_A + 56'h40, 4'd2, 1'b0);
    send(BASE_A + 56'h08, 4'd3, 1'b0);
    req = 1'b0;
    check("pre_rst_err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_rvalid", 64'(rvalid), 64'd0);
    check("rst_mid_gnt", 64'(gnt), 64'd0);
    check("rst_mid_err_cnt", 64'(err_cnt), 64'd0);
    sb.delete();
    exp_err_cnt = 16'd0;
    tick(p);
    tick(p);
    rst = 1'b0;
    rready = 1'b1;
    repeat (5) tick(p);
    check("post_rst_rvalid", 64'(rvalid), 64'd0);
    check("post_rst_err_cnt", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
